// File: rtl/mc_sequencer_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer:
// the stage encoding, trap cause codes and the interrupt cause base.
package mc_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC     = 3'd2,
    WAIT_ALU = 3'd3,
    MEM      = 3'd4,
    WB       = 3'd5,
    NEXT_PC  = 3'd6,
    TRAP     = 3'd7
  } stage_t;

  localparam logic [31:0] CAUSE_MISALIGNED  = 32'd0;
  localparam logic [31:0] CAUSE_FETCH_FAULT = 32'd1;
  localparam logic [31:0] CAUSE_LOAD_FAULT  = 32'd5;
  localparam logic [31:0] CAUSE_STORE_FAULT = 32'd7;
  localparam logic [31:0] IRQ_CAUSE_BASE    = 32'd16;
  localparam logic [31:0] CAUSE_INT_BIT     = 32'h8000_0000;

  function automatic logic [31:0] irq_cause(input logic [3:0] idx);
    return CAUSE_INT_BIT | (IRQ_CAUSE_BASE + {28'd0, idx});
  endfunction

endpackage

// File: rtl/mc_sequencer_irq_prio_enc.sv
// Lowest-index-wins priority encoder for the pending, enabled interrupt lines.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [3:0]   idx_o,
  output logic         valid_o
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx_o   = 4'd0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with memory timeouts,
// misaligned-target and interrupt traps.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = 32'h8000_0000,
  parameter int               MEM_TIMEOUT = 16,
  parameter int               N_IRQ       = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_fetch_o,
  input  logic              mem_ready_i,
  input  logic              mem_err_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       instr_o,
  output logic              dec_valid_o,
  input  logic              ctl_mem_i,
  input  logic              ctl_store_i,
  input  logic              ctl_reg_write_i,
  input  logic              ctl_jump_i,
  input  logic              ctl_branch_i,
  input  logic              ctl_exc_req_i,
  input  logic [3:0]        ctl_exc_cause_i,
  input  logic              ctl_xret_i,
  output logic              alu_start_o,
  input  logic              alu_done_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic              branch_taken_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  input  logic [N_IRQ-1:0]  irq_i,
  input  logic [N_IRQ-1:0]  irq_en_i,
  output logic              rf_we_o,
  output logic              trap_o,
  output logic [31:0]       trap_cause_o,
  output logic [XLEN-1:0]   trap_epc_o,
  output logic [XLEN-1:0]   trap_tval_o,
  output logic [XLEN-1:0]   pc_o,
  output stage_t            state_o
);

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [7:0]      WAIT_MAX = 8'(MEM_TIMEOUT - 1);

  stage_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       cause_q, cause_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [7:0]        wait_q, wait_d;

  logic [XLEN-1:0]   target_s;
  logic [XLEN-1:0]   trap_vec_s;
  logic [3:0]        irq_idx_s;
  logic              irq_valid_s;
  logic              timeout_s;

  irq_prio_enc #(.N(N_IRQ)) u_irq_prio_enc (
    .req_i   (irq_i & irq_en_i),
    .idx_o   (irq_idx_s),
    .valid_o (irq_valid_s)
  );

  assign timeout_s  = (wait_q == WAIT_MAX);
  assign trap_vec_s = mtvec_i & ~XLEN'(3);

  // Next-PC candidate in priority order: xret, jump, taken branch, sequential.
  always_comb begin
    if (ctl_xret_i) begin
      target_s = mepc_i;
    end else if (ctl_jump_i) begin
      target_s = {alu_result_i[XLEN-1:1], 1'b0};
    end else if (ctl_branch_i && branch_taken_i) begin
      target_s = alu_result_i;
    end else begin
      target_s = pc_q + PC_STEP;
    end
  end

  // Sequencer state and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cause_q <= 32'd0;
      epc_q   <= '0;
      tval_q  <= '0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; trap details are captured on the way into TRAP.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    wait_d  = wait_q;
    case (state_q)
      FETCH: begin
        if (mem_err_i || (!mem_ready_i && timeout_s)) begin
          state_d = TRAP;
          cause_d = CAUSE_FETCH_FAULT;
          epc_d   = pc_q;
          tval_d  = pc_q;
        end else if (mem_ready_i) begin
          state_d = DECODE;
          instr_d = mem_rdata_i;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        if (ctl_exc_req_i) begin
          state_d = TRAP;
          cause_d = {28'd0, ctl_exc_cause_i};
          epc_d   = pc_q;
          tval_d  = '0;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = WAIT_ALU;
      end
      WAIT_ALU: begin
        if (!alu_done_i) begin
          state_d = WAIT_ALU;
        end else if (ctl_mem_i) begin
          state_d = MEM;
          wait_d  = 8'd0;
        end else if (ctl_reg_write_i) begin
          state_d = WB;
        end else begin
          state_d = NEXT_PC;
        end
      end
      MEM: begin
        if (mem_err_i || (!mem_ready_i && timeout_s)) begin
          state_d = TRAP;
          cause_d = ctl_store_i ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
          epc_d   = pc_q;
          tval_d  = alu_result_i;
        end else if (mem_ready_i) begin
          state_d = ctl_reg_write_i ? WB : NEXT_PC;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WB: begin
        state_d = NEXT_PC;
      end
      NEXT_PC: begin
        if (target_s[1]) begin
          state_d = TRAP;
          cause_d = CAUSE_MISALIGNED;
          epc_d   = pc_q;
          tval_d  = target_s;
        end else if (irq_valid_s) begin
          state_d = TRAP;
          cause_d = irq_cause(irq_idx_s);
          epc_d   = target_s;
          tval_d  = '0;
        end else begin
          state_d = FETCH;
          pc_d    = target_s;
          wait_d  = 8'd0;
        end
      end
      TRAP: begin
        state_d = FETCH;
        pc_d    = trap_vec_s;
        wait_d  = 8'd0;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Strobes decode the registered stage; requests are held off during reset.
  assign mem_req_o    = !rst && ((state_q == FETCH) || (state_q == MEM));
  assign mem_fetch_o  = !rst && (state_q == FETCH);
  assign mem_addr_o   = (state_q == MEM) ? alu_result_i : pc_q;
  assign dec_valid_o  = (state_q == DECODE);
  assign alu_start_o  = (state_q == EXEC);
  assign rf_we_o      = (state_q == WB);
  assign trap_o       = (state_q == TRAP);
  assign instr_o      = instr_q;
  assign trap_cause_o = cause_q;
  assign trap_epc_o   = epc_q;
  assign trap_tval_o  = tval_q;
  assign pc_o         = pc_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed scoreboard bench for mc_sequencer: expected fetch addresses and
// trap records are queued by the stimulus and consumed by a monitor.
module tb_mc_sequencer;
  import mc_sequencer_pkg::*;

  localparam logic [31:0] RST_PC   = 32'h8000_0000;
  localparam logic [31:0] MTVEC    = 32'h0000_1003;
  localparam logic [31:0] MTVEC_AL = 32'h0000_1000;
  localparam logic [31:0] I_ADD    = 32'h0020_81B3;
  localparam logic [31:0] I_LW     = 32'h0000_A103;
  localparam logic [31:0] I_JAL    = 32'h0000_006F;
  localparam logic [31:0] I_J2     = 32'h0100_006F;
  localparam logic [31:0] I_B      = 32'h0041_0233;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
  } trap_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_req_o, mem_fetch_o, mem_ready_i, mem_err_i;
  logic [31:0] mem_addr_o, mem_rdata_i, instr_o;
  logic dec_valid_o, alu_start_o, alu_done_i, branch_taken_i;
  logic ctl_mem_i, ctl_store_i, ctl_reg_write_i, ctl_jump_i, ctl_branch_i;
  logic ctl_exc_req_i, ctl_xret_i;
  logic [3:0] ctl_exc_cause_i, irq_i, irq_en_i;
  logic [31:0] alu_result_i, mtvec_i, mepc_i;
  logic rf_we_o, trap_o;
  logic [31:0] trap_cause_o, trap_epc_o, trap_tval_o, pc_o;
  stage_t state_o;

  int checks   = 0;
  int failures = 0;
  int rf_cnt   = 0;
  int rf_base;
  int n;
  logic prev_fetch = 1'b0;
  logic [31:0] fetch_q[$];
  trap_exp_t   trap_q[$];

  mc_sequencer dut (
    .clk(clk), .rst(rst),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_fetch_o(mem_fetch_o),
    .mem_ready_i(mem_ready_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
    .instr_o(instr_o), .dec_valid_o(dec_valid_o),
    .ctl_mem_i(ctl_mem_i), .ctl_store_i(ctl_store_i), .ctl_reg_write_i(ctl_reg_write_i),
    .ctl_jump_i(ctl_jump_i), .ctl_branch_i(ctl_branch_i), .ctl_exc_req_i(ctl_exc_req_i),
    .ctl_exc_cause_i(ctl_exc_cause_i), .ctl_xret_i(ctl_xret_i),
    .alu_start_o(alu_start_o), .alu_done_i(alu_done_i), .alu_result_i(alu_result_i),
    .branch_taken_i(branch_taken_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .irq_i(irq_i), .irq_en_i(irq_en_i),
    .rf_we_o(rf_we_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
    .trap_epc_o(trap_epc_o), .trap_tval_o(trap_tval_o), .pc_o(pc_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input stage_t st, input int budget, input string tag);
    int k = 0;
    while (state_o !== st && k < budget) begin
      step();
      k++;
    end
    chk(tag, 64'(state_o), 64'(st));
  endtask

  task automatic wait_trap(input int budget, input string tag);
    int k = 0;
    while (trap_o !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk(tag, 64'(trap_o), 64'd1);
  endtask

  // Serve one fetch: idle for `wcyc` cycles, then respond for one cycle.
  task automatic do_fetch(input int wcyc, input logic [31:0] data, input logic err);
    wait_state(FETCH, 40, "reach_fetch");
    repeat (wcyc) step();
    mem_ready_i = 1'b1;
    mem_err_i   = err;
    mem_rdata_i = data;
    step();
    mem_ready_i = 1'b0;
    mem_err_i   = 1'b0;
  endtask

  task automatic set_ctl(input logic m, input logic rw, input logic j, input logic [31:0] alu);
    ctl_mem_i       = m;
    ctl_reg_write_i = rw;
    ctl_jump_i      = j;
    alu_result_i    = alu;
  endtask

  // Monitor: consume scoreboard entries as fetches start and traps fire.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_o && mem_fetch_o && !prev_fetch) begin
        chk("fetch_queued", 64'(fetch_q.size() > 0), 64'd1);
        if (fetch_q.size() > 0) chk("fetch_addr", 64'(mem_addr_o), 64'(fetch_q.pop_front()));
      end
      if (trap_o) begin
        chk("trap_queued", 64'(trap_q.size() > 0), 64'd1);
        if (trap_q.size() > 0) begin
          trap_exp_t e;
          e = trap_q.pop_front();
          chk("trap_cause", 64'(trap_cause_o), 64'(e.cause));
          chk("trap_epc", 64'(trap_epc_o), 64'(e.epc));
          chk("trap_tval", 64'(trap_tval_o), 64'(e.tval));
        end
      end
      if (rf_we_o) begin
        rf_cnt++;
        chk("rf_we_with_trap", 64'(trap_o), 64'd0);
      end
    end
    prev_fetch <= mem_req_o && mem_fetch_o;
  end

  initial begin
    rst = 1'b1;
    mem_ready_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'd0;
    ctl_store_i = 1'b0; ctl_branch_i = 1'b0; ctl_exc_req_i = 1'b0;
    ctl_exc_cause_i = 4'd0; ctl_xret_i = 1'b0; branch_taken_i = 1'b0;
    alu_done_i = 1'b1; mtvec_i = MTVEC; mepc_i = 32'h8000_0040;
    irq_i = 4'd0; irq_en_i = 4'hF;
    set_ctl(1'b0, 1'b1, 1'b0, 32'd0);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", 64'(pc_o), 64'(RST_PC));
    chk("rst_state", 64'(state_o), 64'(FETCH));
    chk("rst_strobes", 64'({mem_req_o, dec_valid_o, alu_start_o, rf_we_o, trap_o}), 64'd0);
    chk("rst_regs", 64'(instr_o | trap_cause_o | trap_epc_o | trap_tval_o), 64'd0);

    // ADD, fetch ready after 3 wait cycles
    fetch_q.push_back(RST_PC);
    @(posedge clk); #1;
    rst = 1'b0;
    rf_base = rf_cnt;
    do_fetch(3, I_ADD, 1'b0);
    n = 0;
    while (state_o !== FETCH && n < 20) begin step(); n++; end
    chk("add_latency", 64'(n), 64'd5);
    chk("add_pc", 64'(pc_o), 64'h8000_0004);
    chk("add_instr", 64'(instr_o), 64'(I_ADD));
    chk("add_rf_pulses", 64'(rf_cnt - rf_base), 64'd1);

    // Load with no ready: trap on cycle 17 of the wait
    fetch_q.push_back(32'h8000_0004);
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0000_2000);
    rf_base = rf_cnt;
    do_fetch(0, I_LW, 1'b0);
    wait_state(MEM, 10, "ld_reach_mem");
    trap_q.push_back('{CAUSE_LOAD_FAULT, 32'h8000_0004, 32'h0000_2000});
    chk("ld_addr", 64'(mem_addr_o), 64'h2000);
    chk("ld_req", 64'({mem_req_o, mem_fetch_o}), 64'b10);
    n = 1;
    while (trap_o !== 1'b1 && n < 40) begin step(); n++; end
    chk("ld_timeout_cycle", 64'(n), 64'd17);
    fetch_q.push_back(MTVEC_AL);
    step();
    chk("ld_pc_mtvec", 64'(pc_o), 64'(MTVEC_AL));
    chk("ld_no_rf", 64'(rf_cnt - rf_base), 64'd0);

    // Jump to a misaligned target
    set_ctl(1'b0, 1'b0, 1'b1, 32'h8000_0102);
    trap_q.push_back('{CAUSE_MISALIGNED, MTVEC_AL, 32'h8000_0102});
    rf_base = rf_cnt;
    do_fetch(1, I_JAL, 1'b0);
    wait_trap(20, "jmp_trap");
    chk("jmp_no_rf", 64'(rf_cnt - rf_base), 64'd0);
    fetch_q.push_back(MTVEC_AL);
    step();

    // Jump to 0x8000_0010, then interrupt during its successor's NEXT_PC
    set_ctl(1'b0, 1'b0, 1'b1, 32'h8000_0010);
    do_fetch(0, I_J2, 1'b0);
    fetch_q.push_back(32'h8000_0010);
    wait_state(FETCH, 20, "j2_done");
    chk("j2_pc", 64'(pc_o), 64'h8000_0010);
    set_ctl(1'b0, 1'b1, 1'b0, 32'h0000_0000);
    do_fetch(2, I_B, 1'b0);
    wait_state(NEXT_PC, 20, "irq_reach_npc");
    irq_i = 4'b1010;
    trap_q.push_back('{32'h8000_0011, 32'h8000_0014, 32'd0});
    wait_trap(5, "irq_trap");
    irq_i = 4'd0;
    fetch_q.push_back(MTVEC_AL);
    step();
    chk("irq_pc_mtvec", 64'(pc_o), 64'(MTVEC_AL));

    // Fetch with ready and error together: error wins
    set_ctl(1'b0, 1'b0, 1'b0, 32'd0);
    trap_q.push_back('{CAUSE_FETCH_FAULT, MTVEC_AL, MTVEC_AL});
    do_fetch(0, 32'hDEAD_BEEF, 1'b1);
    wait_trap(3, "ferr_trap");
    chk("ferr_instr_kept", 64'(instr_o), 64'(I_B));
    fetch_q.push_back(MTVEC_AL);
    step();

    // Reset while waiting on the ALU
    set_ctl(1'b0, 1'b1, 1'b0, 32'd0);
    alu_done_i = 1'b0;
    do_fetch(0, I_ADD, 1'b0);
    wait_state(WAIT_ALU, 10, "rw_reach_wait");
    step(); step();
    chk("rw_hold", 64'(state_o), 64'(WAIT_ALU));
    rst = 1'b1;
    fetch_q.push_back(RST_PC);
    step(); step();
    chk("rw_rst_state", 64'(state_o), 64'(FETCH));
    chk("rw_rst_pc", 64'(pc_o), 64'(RST_PC));
    chk("rw_rst_cause", 64'(trap_cause_o), 64'd0);
    chk("rw_rst_req", 64'(mem_req_o), 64'd0);
    rst = 1'b0;
    alu_done_i = 1'b1;
    step();
    chk("rw_fetch_req", 64'({mem_req_o, mem_fetch_o}), 64'b11);
    chk("rw_fetch_addr", 64'(mem_addr_o), 64'(RST_PC));
    step();
    rst = 1'b1;
    step(); step();
    chk("fetch_q_empty", 64'(fetch_q.size()), 64'd0);
    chk("trap_q_empty", 64'(trap_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the datapath and PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC loaded on reset.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 16, meaning the number of wait cycles before a memory access faults; legal range is 1 to 255.
REQ-004 SHALL have parameter N_IRQ, default 4, meaning the number of interrupt lines; legal range is 1 to 16.
REQ-005 SHALL have ports: clk in 1, single clock; rst in 1, synchronous, active-high.
REQ-006 SHALL have memory handshake ports:
- mem_req_o out 1
- mem_addr_o out XLEN
- mem_fetch_o out 1: the access is an instruction fetch
- mem_ready_i in 1
- mem_err_i in 1
- mem_rdata_i in 32
REQ-007 SHALL have decode ports:
- instr_o out 32: latched instruction
- dec_valid_o out 1: one-cycle pulse
- ctl_mem_i in 1
- ctl_store_i in 1
- ctl_reg_write_i in 1
- ctl_jump_i in 1
- ctl_branch_i in 1
- ctl_exc_req_i in 1
- ctl_exc_cause_i in 4
- ctl_xret_i in 1
REQ-008 SHALL have ALU ports: alu_start_o out 1; alu_done_i in 1; alu_result_i in XLEN, which carries the data address or jump target; branch_taken_i in 1.
REQ-009 SHALL have CSR/trap ports:
- mtvec_i in XLEN
- mepc_i in XLEN
- irq_i in N_IRQ
- irq_en_i in N_IRQ
- rf_we_o out 1
- trap_o out 1: pulse
- trap_cause_o out 32
- trap_epc_o out XLEN
- trap_tval_o out XLEN
- pc_o out XLEN
- state_o out stage_t

Function
REQ-010 SHALL implement the states FETCH, DECODE, EXEC, WAIT_ALU, MEM, WB, NEXT_PC and TRAP.
REQ-011 In FETCH, SHALL drive mem_req_o=1, mem_fetch_o=1 and mem_addr_o=pc_o.
REQ-012 When FETCH sees mem_ready_i=1 and mem_err_i=0, SHALL latch mem_rdata_i into instr_o and go to DECODE.
REQ-013 In DECODE, SHALL pulse dec_valid_o for one cycle. If ctl_exc_req_i=1, SHALL go to TRAP with cause ctl_exc_cause_i; otherwise SHALL go to EXEC.
REQ-014 In EXEC, SHALL pulse alu_start_o and go to WAIT_ALU. WAIT_ALU SHALL hold until alu_done_i=1.
REQ-015 On leaving WAIT_ALU, SHALL go to MEM if ctl_mem_i=1, else to WB if ctl_reg_write_i=1, else to NEXT_PC.
REQ-016 In MEM, SHALL drive mem_req_o=1 and mem_addr_o=alu_result_i. On ready, SHALL go to WB if ctl_reg_write_i=1, else to NEXT_PC.
REQ-017 In WB, SHALL assert rf_we_o for exactly one cycle, then go to NEXT_PC.
REQ-018 In NEXT_PC, SHALL select the next PC with this priority:
- xret: mepc_i
- jump: {alu_result_i[XLEN-1:1],1'b0}
- branch with branch_taken_i=1: alu_result_i
- otherwise: pc+4, wrapping modulo 2^XLEN
REQ-019 If the selected target has bit 1 set, SHALL raise cause 0 (instruction address misaligned) with tval equal to the target, and SHALL NOT update the PC.
REQ-020 In NEXT_PC, if (irq_i & irq_en_i) is nonzero, SHALL raise an interrupt trap with cause 32'h8000_0000 | (16+i), where i is the lowest set index; epc SHALL be the selected next PC. A misaligned-target trap SHALL take precedence over an interrupt.
REQ-021 SHALL count wait cycles with a counter that resets on every new request. If mem_err_i=1, or MEM_TIMEOUT cycles pass without ready, SHALL go to TRAP with cause 1 (fetch), 5 (load) or 7 (store), and tval equal to the address.
REQ-022 If mem_ready_i and mem_err_i are high together, the error SHALL win.
REQ-023 In TRAP, SHALL pulse trap_o for one cycle, set trap_epc_o to the faulting PC (or to the interrupt epc), load pc_o with {mtvec_i[XLEN-1:2],2'b00}, and go to FETCH.
REQ-024 SHALL never assert rf_we_o in a cycle where a trap is pending.
REQ-025 Instruction retire latency SHALL be fetch wait + 5 cycles for ALU ops with a one-cycle ALU (FETCH, DECODE, EXEC, WAIT_ALU, WB, plus NEXT_PC).

Reset
REQ-026 While rst=1, outputs SHALL be: pc_o=RESET_PC; state=FETCH; mem_req_o, dec_valid_o, alu_start_o, rf_we_o and trap_o = 0; instr_o, trap_cause_o, trap_epc_o and trap_tval_o = 0; timeout counter = 0.
REQ-027 Asserting rst in the middle of an access SHALL abandon it without a trap, and the first request after release SHALL be a fetch from RESET_PC.

Structure
REQ-028 The stage_t enum, the cause codes and the IRQ cause base (16) SHALL live in the Common package.
REQ-029 SHALL contain one sub-module, irq_prio_enc, a parametrised lowest-index priority encoder (N_IRQ in, index and valid out).

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset, then fetch with ready after 3 cycles, ADD → mem_addr_o=0x8000_0000; pc_o=0x8000_0004 after NEXT_PC; rf_we_o high exactly 1 cycle.
- Load whose ready never comes, MEM_TIMEOUT=16 → trap_o on cycle 17 of the wait; cause=5; tval=address; pc_o=mtvec.
- Jump to target 0x8000_0102 → cause 0, tval=0x8000_0102, epc=jump PC, no rf write.
- irq_i=4'b1010 with all enables set during NEXT_PC of pc 0x8000_0010 → cause=0x8000_0011, epc=0x8000_0014.
- mem_ready_i and mem_err_i asserted together on a fetch → cause 1, instr_o unchanged.
- rst pulsed during WAIT_ALU → no trap_o; next mem_addr_o=RESET_PC.
